// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for load-use, flag-use, branch flush, cache-miss freeze and HLT drain
module pipeline_hazard_ctrl #(
  parameter int MISS_TIMEOUT = 255,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ID_EX_MemRead,
  input  logic [3:0]       ID_EX_Rd,
  input  logic             ID_EX_SetsFlags,
  input  logic [3:0]       IF_ID_Rs,
  input  logic [3:0]       IF_ID_Rt,
  input  logic             IF_ID_UsesRt,
  input  logic             IF_ID_IsBranch,
  input  logic             IF_ID_Halt,
  input  logic             BranchTaken,
  input  logic             MEM_WB_Halt,
  input  logic             imiss,
  input  logic             dmiss,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Write,
  output logic             ID_EX_Flush,
  output logic             EX_MEM_Write,
  output logic             MEM_WB_Flush,
  output logic             halted,
  output logic             miss_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [2:0]       state
);
  typedef enum logic [2:0] {RUN = 3'd0, IMISS = 3'd1, DMISS = 3'd2, DRAIN = 3'd3, HALTED = 3'd4} state_t;
  state_t st, nxt;
  logic [CNT_W-1:0] miss_cnt;
  logic hazard, in_miss, enter_miss;
  assign hazard = (ID_EX_MemRead && ID_EX_Rd != 4'd0 &&
                   (ID_EX_Rd == IF_ID_Rs || (IF_ID_UsesRt && ID_EX_Rd == IF_ID_Rt))) ||
                  (IF_ID_IsBranch && ID_EX_SetsFlags);
  assign state = st;
  assign in_miss = st == IMISS || st == DMISS;
  assign enter_miss = (nxt == IMISS || nxt == DMISS) && nxt != st;
  always_comb begin
    PC_Write = 1'b1;
    IF_ID_Write = 1'b1;
    IF_ID_Flush = 1'b0;
    ID_EX_Write = 1'b1;
    ID_EX_Flush = 1'b0;
    EX_MEM_Write = 1'b1;
    MEM_WB_Flush = 1'b0;
    nxt = st;
    if (rst) begin
      PC_Write = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Write = 1'b0;
      EX_MEM_Write = 1'b0;
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
      MEM_WB_Flush = 1'b1;
      nxt = RUN;
    end else if (st == HALTED) begin
      PC_Write = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Write = 1'b0;
      EX_MEM_Write = 1'b0;
      MEM_WB_Flush = 1'b1;
    end else if (dmiss) begin
      PC_Write = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Write = 1'b0;
      EX_MEM_Write = 1'b0;
      MEM_WB_Flush = 1'b1;
      IF_ID_Flush = st == DRAIN;
      nxt = st == DRAIN ? DRAIN : DMISS;
    end else if (st == DRAIN) begin
      PC_Write = 1'b0;
      IF_ID_Flush = 1'b1;
      nxt = MEM_WB_Halt ? HALTED : DRAIN;
    end else if (hazard) begin
      PC_Write = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Flush = 1'b1;
      nxt = st == IMISS && imiss ? IMISS : RUN;
    end else if (imiss) begin
      PC_Write = BranchTaken;
      IF_ID_Flush = 1'b1;
      nxt = BranchTaken || st == DMISS ? RUN : IMISS;
    end else if (BranchTaken) begin
      IF_ID_Flush = 1'b1;
      nxt = RUN;
    end else if (IF_ID_Halt) begin
      PC_Write = 1'b0;
      IF_ID_Flush = 1'b1;
      nxt = DRAIN;
    end else begin
      nxt = RUN;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= RUN;
      halted <= 1'b0;
      miss_timeout <= 1'b0;
      stall_count <= '0;
      miss_cnt <= '0;
    end else begin
      st <= nxt;
      halted <= nxt == HALTED;
      miss_cnt <= enter_miss ? '0 : (in_miss && ~&miss_cnt) ? miss_cnt + 1'b1 : miss_cnt;
      if (miss_cnt == CNT_W'(MISS_TIMEOUT))
        miss_timeout <= 1'b1;
      stall_count <= (!PC_Write && st != HALTED && ~&stall_count) ? stall_count + 1'b1 : stall_count;
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: vector table, corner sequences and random stimulus against a reference model
module tb_pipeline_hazard_ctrl;
  localparam int CW = 5;
  localparam int MT = 4;
  localparam int SAT = (1 << CW) - 1;
  typedef struct packed {
    logic rst, memRead;
    logic [3:0] rd;
    logic setsFlags;
    logic [3:0] rs, rt;
    logic usesRt, isBranch, idHalt, brTaken, wbHalt, imiss, dmiss;
  } vec_t;
  typedef struct {
    vec_t v;
    logic [6:0] outs;
    int st;
    int sc;
  } row_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, ID_EX_MemRead, ID_EX_SetsFlags, IF_ID_UsesRt, IF_ID_IsBranch, IF_ID_Halt;
  logic BranchTaken, MEM_WB_Halt, imiss, dmiss;
  logic [3:0] ID_EX_Rd, IF_ID_Rs, IF_ID_Rt;
  logic PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush, EX_MEM_Write, MEM_WB_Flush;
  logic halted, miss_timeout;
  logic [CW-1:0] stall_count;
  logic [2:0] state;
  logic [6:0] outs_dut, seen_outs;
  assign outs_dut = {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush, EX_MEM_Write, MEM_WB_Flush};
  pipeline_hazard_ctrl #(.MISS_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_Rd(ID_EX_Rd),
    .ID_EX_SetsFlags(ID_EX_SetsFlags), .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt),
    .IF_ID_UsesRt(IF_ID_UsesRt), .IF_ID_IsBranch(IF_ID_IsBranch), .IF_ID_Halt(IF_ID_Halt),
    .BranchTaken(BranchTaken), .MEM_WB_Halt(MEM_WB_Halt), .imiss(imiss), .dmiss(dmiss),
    .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
    .ID_EX_Write(ID_EX_Write), .ID_EX_Flush(ID_EX_Flush), .EX_MEM_Write(EX_MEM_Write),
    .MEM_WB_Flush(MEM_WB_Flush), .halted(halted), .miss_timeout(miss_timeout),
    .stall_count(stall_count), .state(state)
  );
  int n_cmp = 0, n_bad = 0;
  int m_st = 0, m_cnt = 0, m_sc = 0;
  bit m_to = 0, m_halt = 0;
  row_t rows[12];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic vec_t mk(input logic r, mr, input logic [3:0] rd, input logic sf,
                              input logic [3:0] rs, rt, input logic ur, ib, ih, bt, wh, im, dm);
    vec_t v;
    v.rst = r; v.memRead = mr; v.rd = rd; v.setsFlags = sf; v.rs = rs; v.rt = rt;
    v.usesRt = ur; v.isBranch = ib; v.idHalt = ih; v.brTaken = bt; v.wbHalt = wh;
    v.imiss = im; v.dmiss = dm;
    return v;
  endfunction
  // 0 reset, 1 dmiss, 2 hazard, 3 imiss+branch, 4 imiss, 5 branch, 6 halt, 7 idle, 8 drain, 9 drain+dmiss, 10 halted
  function automatic int ref_act(input int st, input vec_t v);
    bit haz;
    haz = (v.memRead && v.rd != 0 && (v.rd == v.rs || (v.usesRt && v.rd == v.rt))) || (v.isBranch && v.setsFlags);
    if (v.rst) return 0;
    if (st == 4) return 10;
    if (st == 3) return v.dmiss ? 9 : 8;
    if (v.dmiss) return 1;
    if (haz) return 2;
    if (v.imiss && v.brTaken) return 3;
    if (v.imiss) return 4;
    if (v.brTaken) return 5;
    if (v.idHalt) return 6;
    return 7;
  endfunction
  function automatic logic [6:0] ref_outs(input int act);
    case (act)
      0: return 7'b0010101;
      1: return 7'b0000001;
      2: return 7'b0001110;
      3, 5: return 7'b1111010;
      4, 6, 8: return 7'b0111010;
      9: return 7'b0010001;
      10: return 7'b0000001;
      default: return 7'b1101010;
    endcase
  endfunction
  function automatic int ref_next(input int st, input int act, input vec_t v);
    case (act)
      0: return 0;
      10: return 4;
      8: return v.wbHalt ? 4 : 3;
      9: return 3;
      1: return 2;
      2: return (st == 1 && v.imiss) ? 1 : 0;
      4: return st == 2 ? 0 : 1;
      6: return 3;
      default: return 0;
    endcase
  endfunction
  task automatic step(input vec_t v);
    int act, nst;
    logic [6:0] eo;
    @(negedge clk);
    rst = v.rst; ID_EX_MemRead = v.memRead; ID_EX_Rd = v.rd; ID_EX_SetsFlags = v.setsFlags;
    IF_ID_Rs = v.rs; IF_ID_Rt = v.rt; IF_ID_UsesRt = v.usesRt; IF_ID_IsBranch = v.isBranch;
    IF_ID_Halt = v.idHalt; BranchTaken = v.brTaken; MEM_WB_Halt = v.wbHalt; imiss = v.imiss; dmiss = v.dmiss;
    #1;
    act = ref_act(m_st, v);
    eo = ref_outs(act);
    seen_outs = outs_dut;
    check("outs", outs_dut, eo);
    nst = ref_next(m_st, act, v);
    if (v.rst) begin
      m_st = 0; m_cnt = 0; m_sc = 0; m_to = 0; m_halt = 0;
    end else begin
      if (m_cnt == MT) m_to = 1;
      if (!eo[6] && m_st != 4 && m_sc < SAT) m_sc++;
      if ((nst == 1 || nst == 2) && nst != m_st) m_cnt = 0;
      else if ((m_st == 1 || m_st == 2) && m_cnt < SAT) m_cnt++;
      m_halt = nst == 4;
      m_st = nst;
    end
    @(posedge clk);
    #1;
    check("state", state, m_st);
    check("halted", halted, m_halt);
    check("miss_timeout", miss_timeout, m_to);
    check("stall_count", stall_count, m_sc);
  endtask
  initial begin
    vec_t v;
    rows[0]  = '{mk(1,0,0,0,0,0,0,0,0,0,0,0,0), 7'b0010101, 0, 0};
    rows[1]  = '{mk(0,1,3,0,3,0,0,0,0,0,0,0,0), 7'b0001110, 0, 1};
    rows[2]  = '{mk(0,0,0,0,0,0,0,0,0,0,0,0,0), 7'b1101010, 0, 1};
    rows[3]  = '{mk(0,1,0,0,0,0,1,0,0,0,0,0,0), 7'b1101010, 0, 1};
    rows[4]  = '{mk(0,1,5,0,1,5,0,0,0,0,0,0,0), 7'b1101010, 0, 1};
    rows[5]  = '{mk(0,1,5,0,1,5,1,0,0,0,0,0,0), 7'b0001110, 0, 2};
    rows[6]  = '{mk(0,0,0,1,0,0,0,1,0,1,0,0,0), 7'b0001110, 0, 3};
    rows[7]  = '{mk(0,0,0,0,0,0,0,1,0,1,0,0,0), 7'b1111010, 0, 3};
    rows[8]  = '{mk(0,0,0,0,0,0,0,0,0,1,0,1,0), 7'b1111010, 0, 3};
    rows[9]  = '{mk(0,0,0,0,0,0,0,0,0,0,0,1,0), 7'b0111010, 1, 4};
    rows[10] = '{mk(0,0,0,0,0,0,0,0,0,0,0,0,0), 7'b1101010, 0, 4};
    rows[11] = '{mk(1,0,0,0,0,0,0,0,0,0,0,0,0), 7'b0010101, 0, 0};
    step(mk(1,0,0,0,0,0,0,0,0,0,0,0,0));
    for (int i = 0; i < 12; i++) begin
      step(rows[i].v);
      check($sformatf("tbl%0d_outs", i), seen_outs, rows[i].outs);
      check($sformatf("tbl%0d_state", i), state, rows[i].st);
      check($sformatf("tbl%0d_stall", i), stall_count, rows[i].sc);
    end
    step(mk(1,0,0,0,0,0,0,0,0,0,0,0,0));
    for (int i = 0; i < 5; i++) begin
      step(mk(0,1,3,0,3,0,0,0,0,0,0,1,1));
      check("frz_outs", seen_outs, 7'b0000001);
      check("frz_state", state, 2);
    end
    step(mk(0,1,3,0,3,0,0,0,0,0,0,1,0));
    check("post_dmiss_haz_outs", seen_outs, 7'b0001110);
    check("post_dmiss_state", state, 0);
    step(mk(0,0,0,0,0,0,0,0,0,0,0,1,0));
    check("post_dmiss_imiss_outs", seen_outs, 7'b0111010);
    check("post_dmiss_imiss_state", state, 1);
    step(mk(1,0,0,0,0,0,0,0,0,0,0,0,0));
    for (int i = 0; i < 6; i++) begin
      step(mk(0,0,0,0,0,0,0,0,0,0,0,1,0));
      check($sformatf("to_cycle%0d", i), miss_timeout, i >= 5);
    end
    for (int i = 0; i < 2; i++) begin
      step(mk(0,0,0,0,0,0,0,0,0,0,0,0,0));
      check("to_sticky", miss_timeout, 1);
    end
    step(mk(0,0,0,0,0,0,0,0,0,1,0,1,0));
    check("imiss_branch_outs", seen_outs, 7'b1111010);
    step(mk(1,0,0,0,0,0,0,0,0,0,0,0,0));
    step(mk(0,0,0,0,0,0,0,0,1,0,0,0,0));
    check("hlt_outs", seen_outs, 7'b0111010);
    check("hlt_state", state, 3);
    for (int i = 0; i < 2; i++) begin
      step(mk(0,0,0,0,0,0,0,0,0,0,0,0,0));
      check("drain_state", state, 3);
    end
    step(mk(0,0,0,0,0,0,0,0,0,0,1,0,1));
    check("drain_dmiss_outs", seen_outs, 7'b0010001);
    check("drain_dmiss_state", state, 3);
    step(mk(0,0,0,0,0,0,0,0,0,0,1,0,0));
    check("halt_state", state, 4);
    check("halt_flag", halted, 1);
    step(mk(0,0,0,0,0,0,0,0,0,1,0,1,1));
    check("halted_outs", seen_outs, 7'b0000001);
    check("halted_hold", state, 4);
    step(mk(1,0,0,0,0,0,0,0,0,0,0,0,0));
    step(mk(0,0,0,0,0,0,0,0,1,0,0,0,0));
    step(mk(0,0,0,0,0,0,0,0,0,0,0,0,0));
    step(mk(1,0,0,0,0,0,0,0,0,0,0,0,0));
    check("mid_drain_rst_state", state, 0);
    check("mid_drain_rst_stall", stall_count, 0);
    check("mid_drain_rst_halted", halted, 0);
    for (int i = 0; i < 3000; i++) begin
      v = mk($urandom_range(0, 60) == 0, 1'($urandom), 4'($urandom_range(0, 3)), 1'($urandom),
             4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
             $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
      step(v);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
